// File: rtl/mem_block_mover_if.sv
// mem_block_mover_if: word-addressed data memory port (adr/datain/w/r/dataout).
// Ports:
//   master - initiator side (drives mem_adr, mem_datain, mem_w, mem_r; reads mem_dataout)
//   slave  - memory side (combinational read data returned on mem_dataout)
interface mem_block_mover_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_datain;
    logic              mem_w;
    logic              mem_r;
    logic [DATA_W-1:0] mem_dataout;

    modport master (output mem_adr, mem_datain, mem_w, mem_r, input mem_dataout);
    modport slave  (input mem_adr, mem_datain, mem_w, mem_r, output mem_dataout);
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover: copies a run of words between memory bases, or fills a range with a constant.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start, mode       - one-cycle request (IDLE only); mode 0 = copy, 1 = fill
//   src_base, dst_base, length, fill_value - transfer parameters captured at start
//   abort             - ends a READ/WRITE transfer after the current access
//   mem               - memory master port
//   busy, done, aborted - status; done/aborted are one-cycle completion pulses
//   checksum          - modular sum of words written this transfer (MOVER_CHECKSUM_EN only)
module mem_block_mover #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    mem_block_mover_if.master mem,
    output logic              busy,
    output logic              done,
    output logic              aborted
`ifdef MOVER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
    state_t state, state_nx;
    logic              mode_q;
    logic              ab_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] buf_q;
    logic              last;
    logic              accept;
    logic              active;

    assign accept = state == IDLE && start;
    assign active = state == READ || state == WRITE;
    assign last   = (idx + LEN_W'(1)) == len_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = length == '0 ? FIN : mode ? WRITE : READ;
            READ:    state_nx = abort ? FIN : WRITE;
            WRITE:   state_nx = (abort || last) ? FIN : mode_q ? WRITE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_r      = state == READ;
        mem.mem_w      = state == WRITE;
        mem.mem_adr    = state == READ  ? src_q + ADDR_W'(idx) :
                         state == WRITE ? dst_q + ADDR_W'(idx) : '0;
        mem.mem_datain = state == WRITE ? (mode_q ? fill_q : buf_q) : '0;
        busy           = state != IDLE;
        done           = state == FIN && !ab_q;
        aborted        = state == FIN && ab_q;
    end

    // ab_q remembers why FIN was entered so the right completion pulse fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            ab_q     <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            fill_q   <= '0;
            buf_q    <= '0;
`ifdef MOVER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            if (accept) begin
                mode_q   <= mode;
                ab_q     <= 1'b0;
                src_q    <= src_base;
                dst_q    <= dst_base;
                len_q    <= length;
                idx      <= '0;
                fill_q   <= fill_value;
`ifdef MOVER_CHECKSUM_EN
                checksum <= '0;
`endif
            end
            if (state == READ)
                buf_q <= mem.mem_dataout;
            if (state == WRITE) begin
                idx      <= idx + LEN_W'(1);
`ifdef MOVER_CHECKSUM_EN
                checksum <= checksum + mem.mem_datain;
`endif
            end
            if (active && abort)
                ab_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: randomized self-checking bench for mem_block_mover with a 256-word memory model.
module tb_mem_block_mover;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 9;
    localparam logic [DW-1:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [LW-1:0] length = '0;
    logic [DW-1:0] fill_value = '0;
    logic          busy, done, aborted;
`ifdef MOVER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_block_mover_if #(.ADDR_W(AW), .DATA_W(DW)) mbus ();

    mem_block_mover #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .fill_value(fill_value), .abort(abort), .mem(mbus),
        .busy(busy), .done(done), .aborted(aborted)
`ifdef MOVER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] img [256];
    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] exp_sum;
    logic          load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) ram[i] <= img[i];
        end else if (mbus.mem_w) begin
            ram[mbus.mem_adr[7:0]] <= mbus.mem_datain;
        end
    end

    // Poison on idle read data exposes any sampling while mem_r is low.
    assign mbus.mem_dataout = mbus.mem_r ? ram[mbus.mem_adr[7:0]] : POISON;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic load_image();
        for (int i = 0; i < 256; i++) exp_mem[i] = img[i];
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Reference: the first nw words of an ascending transfer, in order.
    task automatic model(input bit m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input int nw, input logic [DW-1:0] f);
        logic [DW-1:0] v;
        exp_sum = '0;
        for (int i = 0; i < nw; i++) begin
            v = m ? f : exp_mem[8'(s[7:0] + 8'(i))];
            exp_mem[8'(d[7:0] + 8'(i))] = v;
            exp_sum = exp_sum + v;
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== exp_mem[i]) begin
                if (bad < 4) $display("FAIL %s word %0d: got %h want %h", name, i, ram[i], exp_mem[i]);
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) n_bad++;
    endtask

    // Drives one transfer from a negedge; abort_at=k aborts during the k-th write,
    // abort_at=0 raises abort together with start. Checks bus rules every cycle.
    task automatic run(input bit m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input int len, input logic [DW-1:0] f, input int abort_at, input bit spam,
                       output int fin_cyc, output bit was_ab, output int nw, output int nr);
        fin_cyc = -1; was_ab = 0; nw = 0; nr = 0;
        start = 1'b1; mode = m; src_base = s; dst_base = d; length = LW'(len); fill_value = f;
        abort = abort_at == 0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int n = 1; n <= 2 * len + 8; n++) begin
            n_cmp++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL busy cycle %0d: got %b want 1", n, busy); end
            n_cmp++;
            if ((mbus.mem_r && mbus.mem_w) || (!mbus.mem_w && mbus.mem_datain !== '0)) begin
                n_bad++;
                $display("FAIL bus_rule cycle %0d: r=%b w=%b datain=%h", n, mbus.mem_r, mbus.mem_w, mbus.mem_datain);
            end
            if (mbus.mem_r) begin
                n_cmp++;
                if (m || mbus.mem_adr !== s + 64'(nr)) begin
                    n_bad++;
                    $display("FAIL rd_adr cycle %0d: got %h want %h (mode %0d)", n, mbus.mem_adr, s + 64'(nr), m);
                end
                nr++;
            end
            if (mbus.mem_w) begin
                n_cmp++;
                if (mbus.mem_adr !== d + 64'(nw)) begin
                    n_bad++;
                    $display("FAIL wr_adr cycle %0d: got %h want %h", n, mbus.mem_adr, d + 64'(nw));
                end
                nw++;
                if (!m) begin
                    n_cmp++;
                    if (nr != nw) begin n_bad++; $display("FAIL alternate cycle %0d: reads %0d writes %0d", n, nr, nw); end
                end
                if (nw == abort_at) abort = 1'b1;
            end
            if (done || aborted) begin
                fin_cyc = n; was_ab = aborted;
                n_cmp++;
                if (done && aborted) begin n_bad++; $display("FAIL pulses: done=%b aborted=%b both high", done, aborted); end
                break;
            end
            if (spam) begin
                start = 1'b1; mode = ~m; src_base = {$urandom, $urandom};
                dst_base = {$urandom, $urandom}; length = 9'd5; fill_value = {$urandom, $urandom};
            end
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
        end
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (fin_cyc < 0) begin n_bad++; $display("FAIL timeout: got no done/aborted want one within %0d cycles", 2 * len + 8); end
        @(negedge clk);
        n_cmp++;
        if (busy || done || aborted || mbus.mem_r || mbus.mem_w || mbus.mem_adr !== '0) begin
            n_bad++;
            $display("FAIL back_to_idle: busy=%b done=%b ab=%b r=%b w=%b adr=%h want all 0",
                     busy, done, aborted, mbus.mem_r, mbus.mem_w, mbus.mem_adr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy || done || aborted || mbus.mem_r || mbus.mem_w || mbus.mem_adr !== '0 || mbus.mem_datain !== '0) begin
            n_bad++;
            $display("FAIL reset: busy=%b done=%b ab=%b r=%b w=%b adr=%h din=%h want all 0",
                     busy, done, aborted, mbus.mem_r, mbus.mem_w, mbus.mem_adr, mbus.mem_datain);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy || done || mbus.mem_r || mbus.mem_w || mbus.mem_adr !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b r=%b w=%b adr=%h want all 0",
                     busy, done, mbus.mem_r, mbus.mem_w, mbus.mem_adr);
        end
`ifdef MOVER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== '0) begin n_bad++; $display("FAIL reset_checksum: got %h want 0", checksum); end
`endif
    endtask

    task automatic test_copy();
        int fc, nw, nr;
        bit ab;
        for (int i = 0; i < 256; i++) img[i] = 64'd1;
        img[5] = 64'hDEAD;
        load_image();
        run(1'b0, 64'd4, 64'd100, 3, '0, -1, 1'b0, fc, ab, nw, nr);
        model(1'b0, 64'd4, 64'd100, 3, '0);
        n_cmp++;
        if (fc != 7 || ab || nw != 3 || nr != 3) begin
            n_bad++;
            $display("FAIL copy_timing: got fin=%0d ab=%0d w=%0d r=%0d want 7 0 3 3", fc, ab, nw, nr);
        end
        n_cmp++;
        if (ram[100] !== 64'd1 || ram[101] !== 64'hDEAD || ram[102] !== 64'd1) begin
            n_bad++;
            $display("FAIL copy_words: got %h %h %h want 1 dead 1", ram[100], ram[101], ram[102]);
        end
        check_mem("copy_mem");
`ifdef MOVER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 64'hDEAF) begin n_bad++; $display("FAIL copy_checksum: got %h want deaf", checksum); end
`endif
    endtask

    task automatic test_fill();
        int fc, nw, nr;
        bit ab;
        run(1'b1, 64'd7, 64'd200, 4, 64'hA5A5, -1, 1'b0, fc, ab, nw, nr);
        model(1'b1, 64'd7, 64'd200, 4, 64'hA5A5);
        n_cmp++;
        if (fc != 5 || ab || nw != 4 || nr != 0) begin
            n_bad++;
            $display("FAIL fill_timing: got fin=%0d ab=%0d w=%0d r=%0d want 5 0 4 0", fc, ab, nw, nr);
        end
        check_mem("fill_mem");
`ifdef MOVER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== exp_sum) begin n_bad++; $display("FAIL fill_checksum: got %h want %h", checksum, exp_sum); end
`endif
    endtask

    task automatic test_zero_len();
        int fc, nw, nr;
        bit ab;
        run(1'b0, 64'd3, 64'd30, 0, '0, -1, 1'b0, fc, ab, nw, nr);
        n_cmp++;
        if (fc != 1 || ab || nw != 0 || nr != 0) begin
            n_bad++;
            $display("FAIL zero_len: got fin=%0d ab=%0d w=%0d r=%0d want 1 0 0 0", fc, ab, nw, nr);
        end
        check_mem("zero_len_mem");
    endtask

    task automatic test_abort();
        int fc, nw, nr;
        bit ab;
        for (int i = 0; i < 256; i++) img[i] = {$urandom, $urandom};
        load_image();
        run(1'b0, 64'd0, 64'd50, 10, '0, 3, 1'b1, fc, ab, nw, nr);
        model(1'b0, 64'd0, 64'd50, 3, '0);
        n_cmp++;
        if (fc != 7 || !ab || nw != 3 || nr != 3) begin
            n_bad++;
            $display("FAIL abort: got fin=%0d ab=%0d w=%0d r=%0d want 7 1 3 3", fc, ab, nw, nr);
        end
        check_mem("abort_mem");
    endtask

    task automatic test_start_wins();
        int fc, nw, nr;
        bit ab;
        run(1'b1, 64'd0, 64'd10, 2, 64'h1234, 0, 1'b0, fc, ab, nw, nr);
        model(1'b1, 64'd0, 64'd10, 2, 64'h1234);
        n_cmp++;
        if (fc != 3 || ab || nw != 2) begin
            n_bad++;
            $display("FAIL start_wins: got fin=%0d ab=%0d w=%0d want 3 0 2", fc, ab, nw);
        end
        check_mem("start_wins_mem");
    endtask

    task automatic test_overlap();
        int fc, nw, nr;
        bit ab;
        for (int i = 0; i < 256; i++) img[i] = 64'(i * 3 + 1);
        load_image();
        run(1'b0, 64'd10, 64'd12, 6, '0, -1, 1'b0, fc, ab, nw, nr);
        model(1'b0, 64'd10, 64'd12, 6, '0);
        n_cmp++;
        if (ram[16] !== 64'd31 || ram[17] !== 64'd34) begin
            n_bad++;
            $display("FAIL overlap_words: got %h %h want 1f 22", ram[16], ram[17]);
        end
        check_mem("overlap_mem");
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        logic [DW-1:0] f;
        for (int i = 0; i < 256; i++) img[i] = {$urandom, $urandom};
        load_image();
        f = {$urandom, $urandom};
        start = 1'b1; mode = 1'b1; dst_base = 64'd60; length = 9'd8; fill_value = f;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20 && nw < 3; n++) begin
            if (mbus.mem_w) nw++;
            if (nw < 3) @(negedge clk);
        end
        n_cmp++;
        if (nw != 3) begin n_bad++; $display("FAIL reset_mid_writes: got %0d want 3", nw); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy || done || aborted || mbus.mem_r || mbus.mem_w || mbus.mem_adr !== '0 || mbus.mem_datain !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b ab=%b r=%b w=%b adr=%h din=%h want all 0",
                     busy, done, aborted, mbus.mem_r, mbus.mem_w, mbus.mem_adr, mbus.mem_datain);
        end
`ifdef MOVER_CHECKSUM_EN
        n_cmp++;
        if (checksum !== '0) begin n_bad++; $display("FAIL reset_mid_checksum: got %h want 0", checksum); end
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model(1'b1, 64'd0, 64'd60, 3, f);
        check_mem("reset_mid_mem");
    endtask

`ifdef MOVER_CHECKSUM_EN
    task automatic test_checksum();
        int fc, nw, nr;
        bit ab;
        run(1'b1, 64'd0, 64'd0, 4, 64'd3, -1, 1'b0, fc, ab, nw, nr);
        model(1'b1, 64'd0, 64'd0, 4, 64'd3);
        n_cmp++;
        if (checksum !== 64'd12) begin n_bad++; $display("FAIL checksum_fill: got %0d want 12", checksum); end
        check_mem("checksum_mem");
    endtask
`endif

    task automatic test_random();
        int fc, nw, nr, len, ab_at, want_w;
        bit ab, m;
        logic [AW-1:0] s, d;
        logic [DW-1:0] f;
        for (int t = 0; t < 12; t++) begin
            m = 1'($urandom_range(0, 1));
            s = {$urandom, $urandom};
            d = {$urandom, $urandom};
            f = {$urandom, $urandom};
            len = int'($urandom_range(0, 24));
            ab_at = (len > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : -1;
            want_w = ab_at > 0 ? ab_at : len;
            for (int i = 0; i < 256; i++) img[i] = {$urandom, $urandom};
            load_image();
            run(m, s, d, len, f, ab_at, 1'($urandom_range(0, 1)), fc, ab, nw, nr);
            model(m, s, d, want_w, f);
            n_cmp++;
            if (fc != (m ? want_w + 1 : 2 * want_w + 1) || ab != (ab_at > 0) || nw != want_w || nr != (m ? 0 : want_w)) begin
                n_bad++;
                $display("FAIL random_%0d: got fin=%0d ab=%0d w=%0d r=%0d want fin=%0d ab=%0d w=%0d (mode %0d len %0d)",
                         t, fc, ab, nw, nr, m ? want_w + 1 : 2 * want_w + 1, ab_at > 0, want_w, m, len);
            end
            check_mem($sformatf("random_%0d_mem", t));
`ifdef MOVER_CHECKSUM_EN
            n_cmp++;
            if (checksum !== exp_sum) begin n_bad++; $display("FAIL random_%0d_checksum: got %h want %h", t, checksum, exp_sum); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_zero_len();
        test_abort();
        test_start_wins();
        test_overlap();
        test_reset_mid();
`ifdef MOVER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Initiator-side engine for the team's 64-bit, 256-word data memory port (adr/datain/w/r/dataout).
- Given a start pulse, it copies a run of words from a source base to a destination base, or fills a destination range with a constant.
- Sits between the control/testbench logic and the data memory, replacing hand-driven w/r sequencing.

Parameters:
ADDR_W, 64, width of memory address bus (word-indexed)
DATA_W, 64, width of memory data bus
LEN_W, 9, width of transfer length (max 256 words)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill; captured at start
src_base  input  ADDR_W  source word address (copy), captured at start
dst_base  input  ADDR_W  destination word address, captured at start
length  input  LEN_W  number of words to transfer, captured at start
fill_value  input  DATA_W  fill word (fill mode), captured at start
abort  input  1  terminate transfer at the next edge
mem_adr  output  ADDR_W  to memory adr
mem_datain  output  DATA_W  to memory datain
mem_w  output  1  to memory w
mem_r  output  1  to memory r
mem_dataout  input  DATA_W  from memory dataout (combinational read; Z when r=0)
busy  output  1  high from the cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse on abort completion

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; mem_adr=0, mem_datain=0, mem_w=0, mem_r=0, busy=0, done=0, aborted=0; index and word buffer cleared. Reset mid-transfer: writes committed at earlier edges remain; no further memory access.
- States: IDLE, READ, WRITE, FIN.
- IDLE: mem_r=mem_w=0. If start=1, capture mode/bases/length/fill_value and set index=0.
  - length=0 -> FIN.
  - mode=copy -> READ.
  - mode=fill -> WRITE.
- READ: mem_r=1, mem_adr=src_base+index. mem_dataout is sampled into the word buffer at the closing edge (memory read is combinational). Next state is WRITE.
- WRITE: mem_w=1, mem_adr=dst_base+index, mem_datain=buffer (copy) or fill_value (fill). The memory commits the word at the closing edge. Then index+1.
  - If index+1==length -> FIN.
  - Else copy -> READ, fill -> WRITE.
- FIN: done=1 for one cycle (or aborted=1 if entered by abort), outputs idle. Next state is IDLE.
- Throughput:
  - copy = 2 cycles/word; fill = 1 cycle/word.
  - done asserts 2*length+1 cycles (copy) or length+1 cycles (fill) after the start edge.
- mem_r and mem_w are never high in the same cycle. mem_datain=0 whenever mem_w=0. mem_dataout is never sampled while mem_r=0.
- Address arithmetic is modulo 2^ADDR_W; no range check against memory depth.
- Copy is ascending only. For overlapping ranges with dst>src, results are defined by the sequential ascending order (source words may be overwritten before they are read).
- start while busy: ignored.
- abort in READ/WRITE: the access in that cycle still completes; next state is FIN with aborted=1, done=0.
- abort in IDLE/FIN: ignored.
- abort and start together in IDLE: start wins.

Optional Feature:
- Macro MOVER_CHECKSUM_EN.
- Defined: adds output checksum [DATA_W], the modular sum of every word written during the current transfer. It is cleared on accepted start and on reset, and is stable from the done/aborted pulse until the next start.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> mem_r=mem_w=0, busy=0, done=0, mem_adr=0.
- Copy: memory words 0..31 =1, word 5 preloaded 0xDEAD; start mode=0 src=4 dst=100 len=3 -> words 100,101,102 = 1, 0xDEAD, 1; done at cycle 7 after start; mem_r/mem_w alternate.
- Fill: start mode=1 dst=200 len=4 fill=0xA5A5 -> words 200..203 = 0xA5A5; done 5 cycles after start; mem_r never high.
- Zero length: start len=0 -> no mem_w/mem_r; done one cycle after start.
- Abort: copy len=10 from 0 to 50, abort asserted in the 3rd WRITE -> exactly words 50..52 written, aborted=1 pulse, done stays 0; start pulsed while busy has no effect.
- Reset mid-transfer: fill len=8 at dst=60, rst_n=0 after 3 writes -> only words 60..62 changed; outputs zero the cycle after reset edge; with MOVER_CHECKSUM_EN, fill 4×3 -> checksum=12.
